// File: rtl/water_dispenser_pkg.sv
// Shared types, default constants and width helper for the water dispenser blocks.
package water_dispenser_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDispense = 2'd1,
    StFinish   = 2'd2,
    StFault    = 2'd3
  } disp_state_e;

  localparam int unsigned DefAmountWidth   = 8;
  localparam int unsigned DefPulsesPerUnit = 4;
  localparam int unsigned DefTimeoutCycles = 1000;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/flow_pulse_detector.sv
// Two-flop synchronizer for the raw flow-meter pin plus rising-edge detect.
module flow_pulse_detector (
  input  logic clock,
  input  logic reset,
  input  logic flow_pulse,
  output logic flow_edge
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= flow_pulse;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign flow_edge = sync2_q & ~prev_q;

endmodule

// File: rtl/dispense_sequencer.sv
// Valve sequencer for one order: opens the valve, counts flow units, closes on completion.
// Optional no-flow watchdog enabled by DISPENSE_SEQUENCER_WATCHDOG_EN.
module dispense_sequencer
  import water_dispenser_pkg::*;
#(
  parameter int unsigned AMOUNT_WIDTH    = DefAmountWidth,
  parameter int unsigned PULSES_PER_UNIT = DefPulsesPerUnit,
  parameter int unsigned TIMEOUT_CYCLES  = DefTimeoutCycles
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AMOUNT_WIDTH-1:0] amount,
  input  logic                    cancel,
  input  logic                    flow_pulse,
  output logic                    valve_open,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic [AMOUNT_WIDTH-1:0] dispensed
);

  localparam int unsigned PulseW = cnt_width(PULSES_PER_UNIT);
  localparam logic [PulseW-1:0] PulseLast = PulseW'(PULSES_PER_UNIT - 1);

  disp_state_e state_q, state_d;
  logic [AMOUNT_WIDTH-1:0] amount_q, amount_d;
  logic [AMOUNT_WIDTH-1:0] dispensed_q, dispensed_d, dispensed_inc;
  logic [PulseW-1:0] pulse_q, pulse_d;
  logic flow_edge;
  logic unit_done, final_edge;
  logic wd_expire;

  flow_pulse_detector u_flow_pulse_detector (
    .clock      (clock),
    .reset      (reset),
    .flow_pulse (flow_pulse),
    .flow_edge  (flow_edge)
  );

  assign dispensed_inc = dispensed_q + 1'b1;
  assign unit_done     = flow_edge && (pulse_q == PulseLast);
  assign final_edge    = unit_done && (dispensed_inc == amount_q);

`ifdef DISPENSE_SEQUENCER_WATCHDOG_EN
  localparam int unsigned WdW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q, wd_d;

  // Restarts on every counted edge; idles at zero outside DISPENSE so a fresh start begins at 0.
  always_comb begin
    wd_d = '0;
    if (state_q == StDispense && !flow_edge) begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_expire = (state_q == StDispense) && !flow_edge && (wd_q == WdLast);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign fault = (state_q == StFault);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expire      = 1'b0;
  assign fault          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    amount_d    = amount_q;
    dispensed_d = dispensed_q;
    pulse_d     = pulse_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          amount_d    = amount;
          dispensed_d = '0;
          pulse_d     = '0;
          state_d     = (amount == '0) ? StFinish : StDispense;
        end
      end
      StDispense: begin
        if (flow_edge) begin
          if (unit_done) begin
            pulse_d     = '0;
            dispensed_d = dispensed_inc;
          end else begin
            pulse_d = pulse_q + 1'b1;
          end
        end
        // Completion outranks both cancel and watchdog expiry.
        if (final_edge) begin
          state_d = StFinish;
        end else if (cancel) begin
          state_d = StIdle;
        end else if (wd_expire) begin
          state_d = StFault;
        end
      end
      StFinish: state_d = StIdle;
      StFault: begin
        if (cancel) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      amount_q    <= '0;
      dispensed_q <= '0;
      pulse_q     <= '0;
    end else begin
      state_q     <= state_d;
      amount_q    <= amount_d;
      dispensed_q <= dispensed_d;
      pulse_q     <= pulse_d;
    end
  end

  assign valve_open = (state_q == StDispense);
  assign busy       = (state_q == StDispense) || (state_q == StFinish);
  assign done       = (state_q == StFinish);
  assign dispensed  = dispensed_q;

endmodule
